// File: rtl/hilo_div_unit.sv
// Multi-cycle signed restoring divider that owns the HI/LO register pair.
// Optional fast path for trivial divides is enabled by defining DIV_EARLY_OUT_EN.
module hilo_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              div_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              hilo_we_i,
    input  logic [DATA_W-1:0] hi_wdata_i,
    input  logic [DATA_W-1:0] lo_wdata_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              dz_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
        neg_val = ~v + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        abs_val = v[DATA_W-1] ? neg_val(v) : v;
    endfunction

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [DATA_W-1:0] quo_r, quo_nx_s;
    logic [DATA_W:0]   rem_r, rem_nx_s;
    logic [DATA_W-1:0] dvs_r, dvs_nx_s;
    logic              sign_q_r, sign_q_nx_s;
    logic              sign_r_r, sign_r_nx_s;
    logic              dzc_r, dzc_nx_s;
    logic [DATA_W-1:0] hi_r, hi_nx_s;
    logic [DATA_W-1:0] lo_r, lo_nx_s;
    logic              done_r, done_nx_s;
    logic              dz_r, dz_nx_s;

    logic [DATA_W-1:0] abs_a_s;
    logic [DATA_W-1:0] abs_b_s;
    logic [DATA_W+1:0] shifted_s;
    logic [DATA_W+1:0] diff_s;
    logic              fits_s;

    assign abs_a_s = abs_val(src1_i);
    assign abs_b_s = abs_val(src2_i);

    // One restoring step: remainder||dividend shifted left, trial subtract of the divisor.
    assign shifted_s = {rem_r, quo_r[DATA_W-1]};
    assign diff_s    = shifted_s - {2'b00, dvs_r};
    assign fits_s    = ~diff_s[DATA_W+1];

    // Next-state and datapath update for the divide sequencer and the HI/LO pair.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        quo_nx_s    = quo_r;
        rem_nx_s    = rem_r;
        dvs_nx_s    = dvs_r;
        sign_q_nx_s = sign_q_r;
        sign_r_nx_s = sign_r_r;
        dzc_nx_s    = dzc_r;
        hi_nx_s     = hi_r;
        lo_nx_s     = lo_r;
        done_nx_s   = 1'b0;
        dz_nx_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (div_i) begin
                    quo_nx_s    = abs_a_s;
                    rem_nx_s    = {(DATA_W+1){1'b0}};
                    dvs_nx_s    = abs_b_s;
                    sign_q_nx_s = src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
                    sign_r_nx_s = src1_i[DATA_W-1];
                    dzc_nx_s    = (src2_i == {DATA_W{1'b0}});
                    cnt_nx_s    = CNT_W'(DATA_W);
                    state_nx_s  = CALC;
`ifdef DIV_EARLY_OUT_EN
                    // Trivial divides resolve without iterating.
                    if (abs_b_s == DATA_W'(1)) begin
                        quo_nx_s   = abs_a_s;
                        rem_nx_s   = {(DATA_W+1){1'b0}};
                        cnt_nx_s   = {CNT_W{1'b0}};
                        state_nx_s = FIX;
                    end else if ((abs_b_s != {DATA_W{1'b0}}) && (abs_a_s < abs_b_s)) begin
                        quo_nx_s   = {DATA_W{1'b0}};
                        rem_nx_s   = {1'b0, abs_a_s};
                        cnt_nx_s   = {CNT_W{1'b0}};
                        state_nx_s = FIX;
                    end else begin
                        state_nx_s = CALC;
                    end
`endif
                end else if (hilo_we_i) begin
                    hi_nx_s = hi_wdata_i;
                    lo_nx_s = lo_wdata_i;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (fits_s) begin
                    rem_nx_s = diff_s[DATA_W:0];
                    quo_nx_s = {quo_r[DATA_W-2:0], 1'b1};
                end else begin
                    rem_nx_s = shifted_s[DATA_W:0];
                    quo_nx_s = {quo_r[DATA_W-2:0], 1'b0};
                end
                cnt_nx_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = CALC;
                end
            end
            FIX: begin
                // A zero divisor leaves the dividend as the remainder; only LO is forced.
                if (dzc_r) begin
                    lo_nx_s = {DATA_W{1'b1}};
                end else if (sign_q_r) begin
                    lo_nx_s = neg_val(quo_r);
                end else begin
                    lo_nx_s = quo_r;
                end
                if (sign_r_r) begin
                    hi_nx_s = neg_val(rem_r[DATA_W-1:0]);
                end else begin
                    hi_nx_s = rem_r[DATA_W-1:0];
                end
                done_nx_s  = 1'b1;
                dz_nx_s    = dzc_r;
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers; async reset aborts any divide in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            quo_r    <= {DATA_W{1'b0}};
            rem_r    <= {(DATA_W+1){1'b0}};
            dvs_r    <= {DATA_W{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            dzc_r    <= 1'b0;
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            quo_r    <= quo_nx_s;
            rem_r    <= rem_nx_s;
            dvs_r    <= dvs_nx_s;
            sign_q_r <= sign_q_nx_s;
            sign_r_r <= sign_r_nx_s;
            dzc_r    <= dzc_nx_s;
            hi_r     <= hi_nx_s;
            lo_r     <= lo_nx_s;
            done_r   <= done_nx_s;
            dz_r     <= dz_nx_s;
        end
    end

    assign hi_o   = hi_r;
    assign lo_o   = lo_r;
    assign busy_o = (state_r != IDLE);
    assign done_o = done_r;
    assign dz_o   = dz_r;

endmodule
